bar_update_scheduler: RTL and testbench



---
 rtl/bar_update_scheduler.sv | 152 +++++++++++++++
 tb/tb_bar_update_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bar_update_scheduler.sv
// Queues bar-position commands from the custom-instruction port and applies them
// to the bar coordinate registers only while the display is in vertical blanking.
module bar_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAR_H      = 100,
    parameter int SCREEN_H   = 600,
    parameter int Y_RESET    = 250
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_dataa,
    output logic        o_done,
    output logic [31:0] o_result,
    input  logic        i_vblank,
    output logic [9:0]  o_ybar1,
    output logic [9:0]  o_ybar2,
    output logic        o_frame_tick
);

    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [9:0]  Y_MAX = 10'(SCREEN_H - BAR_H);
    localparam logic [9:0]  Y_RST = 10'(Y_RESET);

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [10:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            done_q;
    logic [31:0]     result_q, result_d;
    logic [9:0]      ybar1_q, ybar2_q;
    logic            vblank_q, tick_q;

    logic            cmdWrite, cmdRead, full, empty;
    logic            pushEn, popEn, dropEn;
    logic [10:0]     popEntry;
    logic [9:0]      popY;
    logic            unusedDataBits;

    assign unusedDataBits = ^i_dataa[30:11];

    assign cmdWrite = i_start && !i_dataa[31];
    assign cmdRead  = i_start &&  i_dataa[31];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);

    // A pop frees a slot in the same cycle, so a write to a full queue is still accepted then.
    assign pushEn   = cmdWrite && (!full || popEn);
    assign dropEn   = cmdWrite && !pushEn;

    assign popEntry = mem_q[rdPtr_q];
    assign popY     = (popEntry[9:0] > Y_MAX) ? Y_MAX : popEntry[9:0];

    // The edge that leaves IDLE already pops, so the first update lands on the first blanking edge.
    always_comb begin
        state_d = state_q;
        popEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_vblank && !empty) begin
                    popEn   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_vblank || empty) begin
                    state_d = IDLE;
                end else begin
                    popEn = 1'b1;
                    if (count_q == CW'(1) && !pushEn) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + CW'(1);
        end else if (popEn && !pushEn) begin
            count_d = count_q - CW'(1);
        end
    end

    // A drop in the same cycle as a status read leaves the sticky flag set.
    always_comb begin
        ovf_d    = ovf_q;
        result_d = '0;
        if (dropEn) begin
            ovf_d    = 1'b1;
            result_d = 32'd1;
        end else if (cmdRead) begin
            ovf_d    = 1'b0;
            result_d = {5'b0, ovf_q, full, 5'(count_q), ybar2_q, ybar1_q};
        end
    end

    always_ff @(posedge i_clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= {i_dataa[10], i_dataa[9:0]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ybar1_q  <= Y_RST;
            ybar2_q  <= Y_RST;
            vblank_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= i_start;
            result_q <= result_d;
            vblank_q <= i_vblank;
            tick_q   <= i_vblank && !vblank_q;
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + PW'(1);
                if (popEntry[10]) begin
                    ybar2_q <= popY;
                end else begin
                    ybar1_q <= popY;
                end
            end
        end
    end

    assign o_done       = done_q;
    assign o_result     = result_q;
    assign o_ybar1      = ybar1_q;
    assign o_ybar2      = ybar2_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_bar_update_scheduler.sv
// Directed bench for bar_update_scheduler: handshake, blanking-gated updates,
// clamping, overflow reporting and asynchronous reset during a drain.
module tb_bar_update_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;
    logic        vblank;
    logic [9:0]  ybar1;
    logic [9:0]  ybar2;
    logic        frameTick;

    int compared;
    int mismatched;
    logic [31:0] res;

    bar_update_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_dataa      (dataa),
        .o_done       (done),
        .o_result     (result),
        .i_vblank     (vblank),
        .o_ybar1      (ybar1),
        .o_ybar2      (ybar2),
        .o_frame_tick (frameTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one instruction and returns its result; checks the one-cycle done pulse.
    task automatic applyStimulus(input logic [31:0] word, output logic [31:0] res_o);
        @(posedge clk); #1;
        start = 1'b1;
        dataa = word;
        @(posedge clk); #1;
        start = 1'b0;
        dataa = '0;
        checkOutput("done_high", 32'(done), 32'd1);
        res_o = result;
        @(posedge clk); #1;
        checkOutput("done_low", 32'(done), 32'd0);
    endtask

    task automatic blank(input int cycles);
        @(posedge clk); #1;
        vblank = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        vblank = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        vblank = 1'b0;

        #12;
        checkOutput("rst_ybar1", 32'(ybar1), 32'd250);
        checkOutput("rst_ybar2", 32'(ybar2), 32'd250);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_tick", 32'(frameTick), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(32'h8000_0000, res);
        checkOutput("status_after_reset", res, 32'd256250);

        applyStimulus(32'h0000_0064, res);
        checkOutput("write_result", res, 32'd0);
        checkOutput("no_update_outside_blank", 32'(ybar1), 32'd250);
        vblank = 1'b1;
        @(posedge clk); #1;
        checkOutput("frame_tick_high", 32'(frameTick), 32'd1);
        @(posedge clk); #1;
        checkOutput("frame_tick_low", 32'(frameTick), 32'd0);
        checkOutput("ybar1_applied", 32'(ybar1), 32'd100);
        vblank = 1'b0;

        applyStimulus(32'h0000_0400 | 32'd700, res);
        checkOutput("write_bar2_result", res, 32'd0);
        blank(3);
        checkOutput("ybar2_clamped", 32'(ybar2), 32'd500);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(32'(i), res);
            checkOutput("fill_result", res, (i == 5) ? 32'd1 : 32'd0);
        end
        applyStimulus(32'h8000_0000, res);
        checkOutput("status_full_ovf", res, 32'd105369700);
        applyStimulus(32'h8000_0000, res);
        checkOutput("status_ovf_cleared", res, 32'd38260836);
        blank(6);
        checkOutput("drain_last_wins", 32'(ybar1), 32'd4);
        applyStimulus(32'h8000_0000, res);
        checkOutput("status_drained", res, 32'd512004);

        applyStimulus(32'd10, res);
        applyStimulus(32'd20, res);
        applyStimulus(32'd30, res);
        blank(2);
        checkOutput("short_blank_ybar1", 32'(ybar1), 32'd20);
        applyStimulus(32'h8000_0000, res);
        checkOutput("short_blank_count", res, 32'd1560596);
        blank(3);
        checkOutput("next_blank_ybar1", 32'(ybar1), 32'd30);

        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dataa = 32'h0000_0400 | 32'(40 + 10 * i);
            @(posedge clk); #1;
            if (i > 0) begin
                checkOutput("b2b_done", 32'(done), 32'd1);
                checkOutput("b2b_result", result, 32'd0);
            end
        end
        start = 1'b0;
        dataa = '0;
        checkOutput("b2b_done_last", 32'(done), 32'd1);
        vblank = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_done_end", 32'(done), 32'd0);
        checkOutput("drain_first_pop", 32'(ybar2), 32'd40);
        start = 1'b1;
        dataa = 32'h8000_0000;
        #2;
        rst    = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        vblank = 1'b0;
        #1;
        checkOutput("async_rst_ybar1", 32'(ybar1), 32'd250);
        checkOutput("async_rst_ybar2", 32'(ybar2), 32'd250);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("no_done_after_rst", 32'(done), 32'd0);
        applyStimulus(32'h8000_0000, res);
        checkOutput("status_after_mid_rst", res, 32'd256250);
        blank(3);
        checkOutput("queue_discarded", 32'(ybar2), 32'd250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
